fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, a single-entry
// instruction buffer toward decode, and redirect (branch/flush) handling
// that drains a response already in flight.
package riscv_defs;
  localparam int NB_WORD = 32;
  localparam int NB_ADDR = 32;
endpackage

module fetch_unit
  import riscv_defs::*;
#(
  parameter logic [NB_ADDR-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_branch_taken,
  input  logic [NB_ADDR-1:0] i_branch_addr,
  input  logic               i_flush,
  output logic               o_imem_req,
  output logic [NB_ADDR-1:0] o_imem_addr,
  input  logic               i_imem_ready,
  input  logic               i_imem_valid,
  input  logic [NB_WORD-1:0] i_imem_rdata,
  output logic               o_valid,
  output logic [NB_WORD-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_pc,
  input  logic               i_decode_ready
);

  typedef enum logic [1:0] {FETCH, WAIT_RSP, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] pc_q, pc_d;
  logic [NB_ADDR-1:0] pc_req_q, pc_req_d;
  logic               valid_q, valid_d;
  logic [NB_WORD-1:0] instr_q, instr_d;
  logic [NB_ADDR-1:0] opc_q, opc_d;

  logic redirect;
  logic accept;
  logic consume;

  assign redirect = i_branch_taken || i_flush;
  assign consume  = valid_q && i_decode_ready;
  // Only request when the buffer will have room by the time data returns.
  assign o_imem_req  = (state_q == FETCH) && !i_reset && (!valid_q || i_decode_ready) && !redirect;
  assign o_imem_addr = pc_q;
  assign accept      = o_imem_req && i_imem_ready;

  assign o_valid       = valid_q;
  assign o_instruction = instr_q;
  assign o_pc          = opc_q;

  // Next-state: redirect wins over fill/consume; an in-flight response after
  // a redirect is dropped (DRAIN) so stale code never reaches decode.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_req_d = pc_req_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    if (redirect) begin
      valid_d = 1'b0;
      if (i_branch_taken) pc_d = {i_branch_addr[NB_ADDR-1:2], 2'b00};
      case (state_q)
        WAIT_RSP: state_d = i_imem_valid ? FETCH : DRAIN;
        DRAIN:    state_d = i_imem_valid ? FETCH : DRAIN;
        default:  state_d = FETCH;
      endcase
    end else begin
      if (consume) valid_d = 1'b0;
      case (state_q)
        FETCH: begin
          if (accept) begin
            pc_req_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (i_imem_valid) begin
            valid_d = 1'b1;
            instr_d = i_imem_rdata;
            opc_d   = pc_req_q + 32'd4;
            state_d = FETCH;
          end
        end
        DRAIN: begin
          if (i_imem_valid) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State registers; reset overrides everything, including redirect.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_ADDR;
      pc_req_q <= '0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      opc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_req_q <= pc_req_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table covering the
// main flow, stalls, redirects, pc wrap and reset, then a hand-written
// multi-cycle-latency fetch sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, br, fl, rdy, iv, dr;
  logic [31:0] baddr, rd;
  logic        o_req, o_vld;
  logic [31:0] o_addr, o_ins, o_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_ADDR(32'h0000_0000)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_branch_taken(br), .i_branch_addr(baddr), .i_flush(fl),
    .o_imem_req(o_req), .o_imem_addr(o_addr), .i_imem_ready(rdy),
    .i_imem_valid(iv), .i_imem_rdata(rd),
    .o_valid(o_vld), .o_instruction(o_ins), .o_pc(o_pc),
    .i_decode_ready(dr)
  );

  typedef struct {
    logic        rst, br, fl, rdy, iv, dr;
    logic [31:0] baddr, rd;
    logic        e_req, e_vld;
    logic [31:0] e_addr, e_ins, e_pc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic b, input logic [31:0] ba, input logic f,
                     input logic y, input logic v, input logic [31:0] d, input logic dd,
                     input logic ereq, input logic [31:0] eaddr, input logic evld,
                     input logic [31:0] eins, input logic [31:0] epc);
    vec_t t;
    t.rst = r; t.br = b; t.baddr = ba; t.fl = f; t.rdy = y; t.iv = v; t.rd = d; t.dr = dd;
    t.e_req = ereq; t.e_addr = eaddr; t.e_vld = evld; t.e_ins = eins; t.e_pc = epc;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  localparam logic [31:0] I0 = 32'h1000_0013, I1 = 32'h1000_0113, I2 = 32'h1000_0213;
  localparam logic [31:0] I3 = 32'h1000_0313, I4 = 32'h1000_0413, I5 = 32'h1000_0513;
  localparam logic [31:0] I6 = 32'h1000_0613, I7 = 32'h1000_0713;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  initial begin
    rst = 1'b1; br = 1'b0; fl = 1'b0; rdy = 1'b0; iv = 1'b0; dr = 1'b0;
    baddr = '0; rd = '0;
    repeat (2) @(posedge clk);

    //   rst br baddr        fl rdy iv rdata dr | req addr         vld ins pc
    add(1, 0, 0,            0, 1, 0, 0,   1,   0, 32'h0,        0, 0,  32'h0);   // reset state
    add(0, 0, 0,            0, 1, 0, 0,   1,   1, 32'h0,        0, 0,  32'h0);   // first req @RESET_ADDR
    add(0, 0, 0,            0, 1, 1, I0,  1,   0, 32'h4,        0, 0,  32'h0);
    add(0, 0, 0,            0, 1, 0, 0,   1,   1, 32'h4,        1, I0, 32'h4);
    add(0, 0, 0,            0, 1, 1, I1,  1,   0, 32'h8,        0, I0, 32'h4);
    add(0, 0, 0,            0, 1, 0, 0,   1,   1, 32'h8,        1, I1, 32'h8);
    add(0, 0, 0,            0, 1, 1, I2,  1,   0, 32'hC,        0, I1, 32'h8);
    add(0, 0, 0,            0, 1, 0, 0,   0,   0, 32'hC,        1, I2, 32'hC);   // decode stall x3
    add(0, 0, 0,            0, 1, 0, 0,   0,   0, 32'hC,        1, I2, 32'hC);
    add(0, 0, 0,            0, 1, 0, 0,   0,   0, 32'hC,        1, I2, 32'hC);
    add(0, 0, 0,            0, 1, 0, 0,   1,   1, 32'hC,        1, I2, 32'hC);
    add(0, 0, 0,            0, 1, 0, 0,   1,   0, 32'h10,       0, I2, 32'hC);   // 2-cycle latency
    add(0, 0, 0,            0, 1, 1, I3,  1,   0, 32'h10,       0, I2, 32'hC);
    add(0, 0, 0,            0, 1, 0, 0,   1,   1, 32'h10,       1, I3, 32'h10);
    add(0, 1, 32'h103,      0, 1, 0, 0,   1,   0, 32'h14,       0, I3, 32'h10);  // branch in WAIT_RSP
    add(0, 0, 0,            0, 1, 0, 0,   1,   0, 32'h100,      0, I3, 32'h10);  // DRAIN
    add(0, 0, 0,            0, 1, 1, BAD, 1,   0, 32'h100,      0, I3, 32'h10);  // stale rsp dropped
    add(0, 0, 0,            0, 1, 0, 0,   1,   1, 32'h100,      0, I3, 32'h10);
    add(0, 1, 32'h200,      0, 1, 1, BAD, 1,   0, 32'h104,      0, I3, 32'h10);  // redirect + rsp same cycle
    add(0, 0, 0,            0, 1, 0, 0,   1,   1, 32'h200,      0, I3, 32'h10);  // no DRAIN cycle
    add(0, 0, 0,            0, 1, 1, I4,  1,   0, 32'h204,      0, I3, 32'h10);
    add(0, 0, 0,            1, 1, 0, 0,   1,   0, 32'h204,      1, I4, 32'h204); // flush kills buffer
    add(0, 0, 0,            0, 0, 0, 0,   1,   1, 32'h204,      0, I4, 32'h204); // not ready: hold
    add(0, 0, 0,            0, 1, 0, 0,   1,   1, 32'h204,      0, I4, 32'h204);
    add(0, 0, 0,            0, 1, 1, I5,  1,   0, 32'h208,      0, I4, 32'h204);
    add(0, 1, 32'hFFFF_FFFE,0, 1, 0, 0,   1,   0, 32'h208,      1, I5, 32'h208); // branch to top word
    add(0, 0, 0,            0, 1, 0, 0,   1,   1, 32'hFFFF_FFFC, 0, I5, 32'h208);
    add(0, 0, 0,            0, 1, 1, I6,  1,   0, 32'h0,        0, I5, 32'h208); // pc wraps
    add(0, 0, 0,            0, 1, 0, 0,   1,   1, 32'h0,        1, I6, 32'h0);
    add(1, 0, 0,            0, 1, 0, 0,   1,   0, 32'h4,        0, I6, 32'h0);   // reset in WAIT_RSP
    add(0, 0, 0,            0, 1, 1, BAD, 1,   1, 32'h0,        0, 0,  32'h0);   // stale rsp ignored
    add(0, 0, 0,            0, 1, 1, I7,  1,   0, 32'h4,        0, 0,  32'h0);
    add(0, 0, 0,            0, 1, 0, 0,   0,   0, 32'h4,        1, I7, 32'h4);
    add(1, 1, 32'h300,      0, 1, 0, 0,   0,   0, 32'h4,        1, I7, 32'h4);   // reset beats branch
    add(0, 0, 0,            0, 0, 0, 0,   1,   1, 32'h0,        0, 0,  32'h0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; br = vq[i].br; baddr = vq[i].baddr; fl = vq[i].fl;
      rdy = vq[i].rdy; iv = vq[i].iv; rd = vq[i].rd; dr = vq[i].dr;
      #1;
      chk("imem_req",  i, {31'b0, o_req}, {31'b0, vq[i].e_req});
      chk("imem_addr", i, o_addr, vq[i].e_addr);
      chk("valid",     i, {31'b0, o_vld}, {31'b0, vq[i].e_vld});
      chk("instr",     i, o_ins, vq[i].e_ins);
      chk("pc",        i, o_pc, vq[i].e_pc);
    end

    // Hand-written: 3-cycle response latency, two back-to-back fetches from 0x0.
    for (int k = 0; k < 2; k++) begin
      int n;
      logic [31:0] ea, data;
      ea = 32'(k) * 32'd4;
      data = 32'hCAFE_0000 + 32'(k);
      @(negedge clk);
      rdy = 1'b1; dr = 1'b1; iv = 1'b0; rd = '0;
      #1;
      n = 0;
      while (!o_req && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk("req_timeout", 100 + k, 32'(n < 20), 32'd1);
      chk("seq_addr", 100 + k, o_addr, ea);
      @(posedge clk);
      repeat (2) @(negedge clk);
      @(negedge clk);
      rdy = 1'b0; iv = 1'b1; rd = data;
      @(posedge clk);
      @(negedge clk);
      iv = 1'b0;
      #1;
      chk("seq_valid", 100 + k, {31'b0, o_vld}, 32'd1);
      chk("seq_instr", 100 + k, o_ins, data);
      chk("seq_pc",    100 + k, o_pc, ea + 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
